div_sequencer: RTL and testbench

Multi-cycle controller and datapath sequencer for the processor's signed 32-bit integer divider. It accepts a divide request from the execute stage and runs a restoring shift/subtract loop on operand magnitudes, one quotient bit per cycle. It then applies the quotient sign correction and signals completion with a one-cycle ready pulse. While an operation is in flight it stalls the pipeline through `busy`.

---
 rtl/div_pkg.sv | 19 +
 rtl/div_sign_fix.sv | 13 +
 rtl/div_sequencer.sv | 139 +++++++++++++
 tb/tb_div_sequencer.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing for the signed integer divider sequencer.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DIV_WIDTH = 32;

    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int DIV_CNT_W = cnt_w(DIV_WIDTH);

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate: magnitude extraction and quotient sign fix.
// Purely combinational, no state, no flow control.
module div_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic             i_neg,
    input  logic [WIDTH-1:0] i_val,
    output logic [WIDTH-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + {{(WIDTH-1){1'b0}}, 1'b1}) : i_val;

endmodule

// File: rtl/div_sequencer.sv
// Signed restoring divider sequencer: one quotient bit per cycle, ready pulse WIDTH+1 cycles after start.
// busy stalls the pipeline during RUN/FIX; starts arriving while busy are dropped, not queued.
module div_sequencer
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int              CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_div;
    logic               r_sa;
    logic               r_sb;
    logic [WIDTH-1:0]   r_result;
    logic               r_exc;
    logic               r_rdy;
    logic               r_busy;

    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_fixed;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;
    logic               w_neg;
    logic               w_b_zero;

    div_sign_fix #(.WIDTH(WIDTH)) u_abs_a (
        .i_neg (data_operandA[WIDTH-1]),
        .i_val (data_operandA),
        .o_val (w_abs_a)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_abs_b (
        .i_neg (data_operandB[WIDTH-1]),
        .i_val (data_operandB),
        .o_val (w_abs_b)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_fix (
        .i_neg (r_sa ^ r_sb),
        .i_val (r_quo),
        .o_val (w_fixed)
    );

    // rem < divisor <= 2^(WIDTH-1) keeps the shifted remainder below 2^WIDTH,
    // so the top bit of the WIDTH+1 bit difference is a clean borrow flag.
    assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_div};
    assign w_neg    = w_diff[WIDTH];
    assign w_b_zero = (data_operandB == '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (ctrl_DIV) begin
                        r_sa  <= data_operandA[WIDTH-1];
                        r_sb  <= data_operandB[WIDTH-1];
                        r_rem <= '0;
                        r_quo <= w_abs_a;
                        r_div <= w_abs_b;
                        r_cnt <= '0;
                        if (w_b_zero) begin
                            r_state  <= DONE;
                            r_exc    <= 1'b1;
                            r_result <= '0;
                            r_rdy    <= 1'b1;
                            r_busy   <= 1'b0;
                        end else begin
                            r_state  <= RUN;
                            r_exc    <= 1'b0;
                            r_rdy    <= 1'b0;
                            r_busy   <= 1'b1;
                        end
                    end else begin
                        r_state <= IDLE;
                        r_rdy   <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end

                RUN: begin
                    r_rem <= w_neg ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], ~w_neg};
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_state <= FIX;
                    end
                end

                FIX: begin
                    r_result <= w_fixed;
                    r_state  <= DONE;
                    r_rdy    <= 1'b1;
                    r_busy   <= 1'b0;
                end

                default: begin
                    r_state <= IDLE;
                    r_rdy   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;
    assign busy           = r_busy;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: signs, divide-by-zero, overflow, ignored starts, back-to-back, mid-op reset.
module tb_div_sequencer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;
    int bcnt;
    int rdy_seen;

    div_sequencer #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_DIV      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        @(negedge clock);
        ctrl_DIV = 1'b0;
    endtask

    // Counts cycles after the start edge until ready, sampling on falling edges.
    task automatic wait_rdy(output int l, output int bc);
        l  = 0;
        bc = 0;
        while (data_resultRDY !== 1'b1 && l < 100) begin
            if (busy === 1'b1) bc++;
            @(negedge clock);
            l++;
        end
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic exp_exc, input int exp_lat);
        logic [31:0] held;
        start(a, b);
        wait_rdy(lat, bcnt);
        chk({tag, ".lat"}, lat, exp_lat);
        chk({tag, ".busy_cycles"}, bcnt, exp_lat);
        chk({tag, ".result"}, data_result, exp_res);
        chk({tag, ".exc"}, {31'd0, data_exception}, {31'd0, exp_exc});
        held = exp_res;
        @(negedge clock);
        chk({tag, ".rdy_pulse_end"}, {31'd0, data_resultRDY}, 32'd0);
        chk({tag, ".result_held"}, data_result, held);
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset.result", data_result, 32'd0);
        chk("reset.exc",    {31'd0, data_exception}, 32'd0);
        chk("reset.rdy",    {31'd0, data_resultRDY}, 32'd0);
        chk("reset.busy",   {31'd0, busy}, 32'd0);
        reset_n = 1'b1;

        run("p100_p7",   32'd100,        32'd7,          32'd14,         1'b0, 33);
        run("n100_p7",   32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  1'b0, 33);
        run("p100_n7",   32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  1'b0, 33);
        run("n100_n7",   32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         1'b0, 33);
        run("div0",      32'd5,          32'd0,          32'd0,          1'b1, 0);
        run("ovf",       32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 33);
        run("min_by_1",  32'h8000_0000,  32'd1,          32'h8000_0000,  1'b0, 33);
        run("small",     32'd7,          32'd100,        32'd0,          1'b0, 33);

        // A start pulse in the middle of RUN must be dropped.
        start(32'd100, 32'd7);
        lat = 0;
        while (data_resultRDY !== 1'b1 && lat < 100) begin
            if (lat == 10) begin
                ctrl_DIV      = 1'b1;
                data_operandA = 32'd9;
                data_operandB = 32'd3;
            end else begin
                ctrl_DIV = 1'b0;
            end
            @(negedge clock);
            lat++;
        end
        ctrl_DIV = 1'b0;
        chk("ignored.lat",    lat, 33);
        chk("ignored.result", data_result, 32'd14);

        // Back-to-back: start issued during the DONE cycle.
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'd3;
        @(posedge clock);
        @(negedge clock);
        ctrl_DIV = 1'b0;
        wait_rdy(lat, bcnt);
        chk("b2b.lat",    lat, 33);
        chk("b2b.busy",   bcnt, 33);
        chk("b2b.result", data_result, 32'd3);

        // Asynchronous reset in the middle of an operation.
        start(32'd100, 32'd7);
        repeat (15) @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("midrst.result", data_result, 32'd0);
        chk("midrst.exc",    {31'd0, data_exception}, 32'd0);
        chk("midrst.rdy",    {31'd0, data_resultRDY}, 32'd0);
        chk("midrst.busy",   {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clock);
        reset_n  = 1'b1;
        rdy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1 || busy === 1'b1) rdy_seen++;
        end
        chk("midrst.no_activity", rdy_seen, 0);

        run("post_rst", 32'd20, 32'd4, 32'd5, 1'b0, 33);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
